mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the datapath's data bus (Dw*), downstream of the uniciclo core.
//  CPU stores bytes into a TX FIFO; an FSM serialises them 8N1 on oTx. Status/divider are readable in the same cycle,
//  as the single-cycle core requires (combinational read path).

---
 rtl/mmio_uart_tx_pkg.sv | 34 +++
 rtl/mmio_uart_tx_if.sv | 27 ++
 rtl/mmio_uart_tx_fifo.sv | 68 ++++++
 rtl/mmio_uart_tx.sv | 207 ++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx_pkg
//  Description : Shared definitions for the memory-mapped UART transmitter:
//                register offsets, STATUS bit positions and FSM encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmio_uart_tx_pkg;

    // Register offsets, selected by iAddress[3:2]
    localparam logic [1:0] c_OFF_TXDATA  = 2'd0;
    localparam logic [1:0] c_OFF_STATUS  = 2'd1;
    localparam logic [1:0] c_OFF_BAUDDIV = 2'd2;
    localparam logic [1:0] c_OFF_RSVD    = 2'd3;

    // STATUS bit positions
    localparam int c_ST_FULL    = 0;
    localparam int c_ST_EMPTY   = 1;
    localparam int c_ST_ACTIVE  = 2;
    localparam int c_ST_OVF     = 3;
    localparam int c_ST_PARITY  = 4;
    localparam int c_ST_CNT_LSB = 8;

    // Transmitter FSM states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } txState_t;

endpackage
`default_nettype wire

// File: rtl/mmio_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx_if
//  Description : Data-bus (Dw*) slice seen by the UART: strobes, address,
//                write data, combinational read data and hit flag.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mmio_uart_tx_if;
    logic        iReadEnable;
    logic        iWriteEnable;
    logic [3:0]  iByteEnable;
    logic [31:0] iAddress;
    logic [31:0] iWriteData;
    logic [31:0] oReadData;
    logic        oHit;

    modport master (
        output iReadEnable, iWriteEnable, iByteEnable, iAddress, iWriteData,
        input  oReadData, oHit
    );

    modport slave (
        input  iReadEnable, iWriteEnable, iByteEnable, iAddress, iWriteData,
        output oReadData, oHit
    );
endinterface
`default_nettype wire

// File: rtl/mmio_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Synchronous TX FIFO. A push while full is ignored unless a
//                pop happens in the same cycle; pointers wrap modulo DEPTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  wire logic                     iCLK,
    input  wire logic                     iRST,
    input  wire logic                     iPush,
    input  wire logic [WIDTH-1:0]         iPushData,
    input  wire logic                     iPop,
    output logic      [WIDTH-1:0]         oPopData,
    output logic                          oFull,
    output logic                          oEmpty,
    output logic      [$clog2(DEPTH):0]   oCount
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wrPtr;
    logic [c_AW-1:0]  r_rdPtr;
    logic [c_CW-1:0]  r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign oFull    = (r_count == c_DEPTH);
    assign oEmpty   = (r_count == '0);
    assign oCount   = r_count;
    assign oPopData = r_mem[r_rdPtr];
    assign w_doPop  = iPop & ~oEmpty;
    assign w_doPush = iPush & (~oFull | w_doPop);

    // Storage array: written on every accepted push, never reset
    always_ff @(posedge iCLK) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= iPushData;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx
//  Description : Memory-mapped 8N1 UART transmitter with TX FIFO and a
//                combinational register read path for a single-cycle core.
//                Optional even parity bit when UART_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFF200100,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  wire logic         iCLK,
    input  wire logic         iRST,
    mmio_uart_tx_if.slave     dbus,
    output logic              oTx,
    output logic              oBusy
);
    localparam int c_CW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_PARITY_EN
    localparam logic c_PARITY_EN = 1'b1;
`else
    localparam logic c_PARITY_EN = 1'b0;
`endif

    logic [1:0]      w_offset;
    logic            w_wrEn, w_push, w_divWr, w_ovfClr, w_ovfSet;
    logic            w_full, w_empty, w_pop;
    logic [7:0]      w_fifoData;
    logic [c_CW-1:0] w_count;
    logic [31:0]     w_rdData;
    logic            r_ovf;
    logic [15:0]     r_baudDiv;

    txState_t        r_state, w_stateNext;
    logic [15:0]     r_cnt, w_cntNext;
    logic [15:0]     r_div, w_divNext;
    logic [7:0]      r_byte, w_byteNext;
    logic [2:0]      r_bitIdx, w_bitIdxNext, w_idxInc;
    logic            r_tx, w_txNext, w_tick;

    // Address decode and write strobes
    assign w_offset  = dbus.iAddress[3:2];
    assign dbus.oHit = (dbus.iAddress[31:4] == BASE_ADDR[31:4]);
    assign w_wrEn    = dbus.oHit & dbus.iWriteEnable;
    assign w_push    = w_wrEn & (w_offset == c_OFF_TXDATA) & dbus.iByteEnable[0];
    assign w_divWr   = w_wrEn & (w_offset == c_OFF_BAUDDIV) & (dbus.iByteEnable[1:0] == 2'b11);
    assign w_ovfClr  = w_wrEn & (w_offset == c_OFF_STATUS) & dbus.iWriteData[c_ST_OVF];
    // A push into a full FIFO survives only if the FSM frees a slot this cycle
    assign w_ovfSet  = w_push & w_full & ~w_pop;

    logic w_unused;
    assign w_unused = ^{dbus.iAddress[1:0], dbus.iWriteData[31:16], dbus.iByteEnable[3:2]};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iPush     (w_push),
        .iPushData (dbus.iWriteData[7:0]),
        .iPop      (w_pop),
        .oPopData  (w_fifoData),
        .oFull     (w_full),
        .oEmpty    (w_empty),
        .oCount    (w_count)
    );

    // Sticky overflow flag, cleared by writing STATUS with bit 3 set
    always_ff @(posedge iCLK) begin
        if (iRST)          r_ovf <= 1'b0;
        else if (w_ovfSet) r_ovf <= 1'b1;
        else if (w_ovfClr) r_ovf <= 1'b0;
    end

    // Baud divider register
    always_ff @(posedge iCLK) begin
        if (iRST)         r_baudDiv <= DIV_RESET;
        else if (w_divWr) r_baudDiv <= dbus.iWriteData[15:0];
    end

    // Combinational read mux, zero when not selected
    always_comb begin
        w_rdData = '0;
        if (dbus.oHit & dbus.iReadEnable) begin
            case (w_offset)
                c_OFF_STATUS: begin
                    w_rdData[c_ST_FULL]                  = w_full;
                    w_rdData[c_ST_EMPTY]                 = w_empty;
                    w_rdData[c_ST_ACTIVE]                = (r_state != S_IDLE);
                    w_rdData[c_ST_OVF]                   = r_ovf;
                    w_rdData[c_ST_PARITY]                = c_PARITY_EN;
                    w_rdData[c_ST_CNT_LSB +: 8]          = 8'(w_count);
                end
                c_OFF_BAUDDIV: w_rdData = {16'h0000, r_baudDiv};
                default:       w_rdData = '0;
            endcase
        end
    end
    assign dbus.oReadData = w_rdData;

    // FSM state and serialiser registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_div    <= '0;
            r_byte   <= '0;
            r_bitIdx <= '0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_stateNext;
            r_cnt    <= w_cntNext;
            r_div    <= w_divNext;
            r_byte   <= w_byteNext;
            r_bitIdx <= w_bitIdxNext;
            r_tx     <= w_txNext;
        end
    end

    // Next-state logic; oTx is computed for the upcoming bit so it leaves a flop
    assign w_tick   = (r_cnt == '0);
    assign w_idxInc = r_bitIdx + 3'd1;
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = w_tick ? r_cnt : r_cnt - 16'd1;
        w_divNext    = r_div;
        w_byteNext   = r_byte;
        w_bitIdxNext = r_bitIdx;
        w_txNext     = r_tx;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_stateNext = S_START;
                    w_cntNext   = r_baudDiv;
                    w_divNext   = r_baudDiv;
                    w_byteNext  = w_fifoData;
                    w_txNext    = 1'b0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_stateNext  = S_DATA;
                    w_cntNext    = r_div;
                    w_bitIdxNext = 3'd0;
                    w_txNext     = r_byte[0];
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_cntNext = r_div;
                    if (r_bitIdx == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_stateNext = S_PARITY;
                        w_txNext    = ^r_byte;
`else
                        w_stateNext = S_STOP;
                        w_txNext    = 1'b1;
`endif
                    end else begin
                        w_bitIdxNext = w_idxInc;
                        w_txNext     = r_byte[w_idxInc];
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_stateNext = S_STOP;
                    w_cntNext   = r_div;
                    w_txNext    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (!w_empty) begin
                        // back-to-back frame: no idle gap after the stop bit
                        w_pop       = 1'b1;
                        w_stateNext = S_START;
                        w_cntNext   = r_baudDiv;
                        w_divNext   = r_baudDiv;
                        w_byteNext  = w_fifoData;
                        w_txNext    = 1'b0;
                    end else begin
                        w_stateNext = S_IDLE;
                        w_txNext    = 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_txNext    = 1'b1;
            end
        endcase
    end

    assign oTx   = r_tx;
    assign oBusy = (r_state != S_IDLE) | ~w_empty;
endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_uart_tx
//  Description : Self-checking bench for mmio_uart_tx. A line monitor decodes
//                frames from oTx and compares them with bytes queued at push.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;
    localparam logic [31:0] c_BASE = 32'hFF200100;
`ifdef UART_PARITY_EN
    localparam int          c_FRAME_BITS = 11;
    localparam logic [31:0] c_PAR_FLAG   = 32'h10;
`else
    localparam int          c_FRAME_BITS = 10;
    localparam logic [31:0] c_PAR_FLAG   = 32'h0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic oTx, oBusy;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .BASE_ADDR  (c_BASE),
        .FIFO_DEPTH (16),
        .DIV_RESET  (16'd433)
    ) dut (
        .iCLK  (clk),
        .iRST  (rst),
        .dbus  (bus),
        .oTx   (oTx),
        .oBusy (oBusy)
    );

    always #5 clk = ~clk;

    int         nChecks = 0;
    int         nFails  = 0;
    int         cyc     = 0;
    logic [7:0] expQ[$];
    int         startQ[$];
    bit         monEnable  = 1'b0;
    int         monDiv     = 433;
    int         framesSeen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.iAddress     = a;
        bus.iWriteData   = d;
        bus.iByteEnable  = be;
        bus.iWriteEnable = 1'b1;
        @(posedge clk); #1;
        bus.iWriteEnable = 1'b0;
        bus.iByteEnable  = 4'h0;
    endtask

    task automatic busRead(input logic [31:0] a, input logic re, output logic [31:0] d, output logic hit);
        bus.iAddress    = a;
        bus.iReadEnable = re;
        #1;
        d   = bus.oReadData;
        hit = bus.oHit;
        bus.iReadEnable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pushByte(input logic [7:0] b);
        busWrite(c_BASE, {24'h0, b}, 4'b0001);
        expQ.push_back(b);
    endtask

    task automatic setDiv(input int d);
        busWrite(c_BASE + 32'd8, d, 4'b0011);
        monDiv = d;
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        while ((expQ.size() != 0 || oBusy) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        checkValue("drainTimeout", (expQ.size() != 0 || oBusy), 0);
    endtask

    // Line monitor: samples the first cycle of every bit after a start edge
    initial begin : g_monitor
        int         p;
        logic [7:0] rx;
        logic       par;
        logic       stopBit;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (monEnable && oTx === 1'b0) begin
                p = monDiv + 1;
                startQ.push_back(cyc);
                par = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (p) @(negedge clk);
                    rx[i] = oTx;
                end
`ifdef UART_PARITY_EN
                repeat (p) @(negedge clk);
                par = oTx;
`endif
                repeat (p) @(negedge clk);
                stopBit = oTx;
                checkValue("stopBit", stopBit, 1);
                checkValue("sbNonEmpty", expQ.size() != 0, 1);
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkValue("rxByte", rx, e);
`ifdef UART_PARITY_EN
                    checkValue("parityBit", par, ^e);
`endif
                end
                framesSeen++;
            end
        end
    end

    initial begin : g_watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : g_main
        logic [31:0] rd;
        logic        hit;
        int          n;
        int          f0;

        bus.iReadEnable  = 1'b0;
        bus.iWriteEnable = 1'b0;
        bus.iByteEnable  = 4'h0;
        bus.iAddress     = 32'h0;
        bus.iWriteData   = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        busRead(c_BASE + 32'd4, 1'b1, rd, hit);
        checkValue("rstStatus", rd, 32'h2 | c_PAR_FLAG);
        checkValue("rstHit", hit, 1);
        checkValue("rstTx", oTx, 1);
        checkValue("rstBusy", oBusy, 0);
        busRead(c_BASE + 32'd8, 1'b1, rd, hit);
        checkValue("rstBaudDiv", rd, 433);
        busRead(c_BASE, 1'b1, rd, hit);
        checkValue("txdataReadZero", rd, 0);
        busRead(c_BASE + 32'd12, 1'b1, rd, hit);
        checkValue("rsvdReadZero", rd, 0);
        busWrite(c_BASE + 32'd8, 32'd5, 4'b0001);
        busRead(c_BASE + 32'd8, 1'b1, rd, hit);
        checkValue("divPartialBe", rd, 433);

        monEnable = 1'b1;

        // Single frame 0xA5, exact start latency and busy length
        setDiv(3);
        busRead(c_BASE + 32'd8, 1'b1, rd, hit);
        checkValue("divReadback", rd, 3);
        pushByte(8'hA5);
        checkValue("txIdleAfterPush", oTx, 1);
        @(posedge clk); #1;
        checkValue("startEdge", oTx, 0);
        n = 1;
        while (oBusy && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        checkValue("busyCycles", n, c_FRAME_BITS * 4 + 1);
        checkValue("a5Drained", expQ.size(), 0);

        // Back-to-back frames with no idle gap
        startQ.delete();
        pushByte(8'h00);
        pushByte(8'hFF);
        waitDrain(500);
        checkValue("b2bFrames", startQ.size(), 2);
        if (startQ.size() == 2)
            checkValue("b2bGap", startQ[1] - startQ[0], c_FRAME_BITS * 4);

        // Assorted patterns, including parity-sensitive 07/03, then 1-cycle bits
        setDiv(1);
        pushByte(8'h07);
        pushByte(8'h03);
        pushByte(8'h3C);
        pushByte(8'hC3);
        waitDrain(1000);
        setDiv(0);
        pushByte(8'h96);
        pushByte(8'h01);
        waitDrain(200);

        // Overflow: 17 accepted (one popped immediately), 18th dropped
        f0 = framesSeen;
        setDiv(20);
        for (int i = 0; i < 17; i++) pushByte(8'h10 + i[7:0]);
        busWrite(c_BASE, 32'hEE, 4'b0001);
        busRead(c_BASE + 32'd4, 1'b1, rd, hit);
        checkValue("ovfStatus", rd, 32'h100D | c_PAR_FLAG);
        busWrite(c_BASE + 32'd4, 32'h8, 4'hF);
        busRead(c_BASE + 32'd4, 1'b1, rd, hit);
        checkValue("ovfCleared", rd, 32'h1005 | c_PAR_FLAG);
        waitDrain(17 * c_FRAME_BITS * 21 + 200);
        checkValue("ovfFrames", framesSeen - f0, 17);

        // Reset during data bit 4 of 0x0F with a second byte queued
        monEnable = 1'b0;
        setDiv(3);
        busWrite(c_BASE, 32'h0F, 4'b0001);
        busWrite(c_BASE, 32'h33, 4'b0001);
        repeat (21) @(posedge clk);
        #1;
        checkValue("bit4Level", oTx, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        checkValue("rstMidTx", oTx, 1);
        rst = 1'b0;
        busRead(c_BASE + 32'd4, 1'b1, rd, hit);
        checkValue("rstMidStatus", rd, 32'h2 | c_PAR_FLAG);
        busRead(c_BASE + 32'd8, 1'b1, rd, hit);
        checkValue("rstMidDiv", rd, 433);
        repeat (30) @(posedge clk);
        #1;
        checkValue("postRstTx", oTx, 1);
        checkValue("postRstBusy", oBusy, 0);

        // Out-of-window and unselected accesses
        busRead(c_BASE + 32'd16, 1'b1, rd, hit);
        checkValue("outHit", hit, 0);
        checkValue("outData", rd, 0);
        busWrite(c_BASE + 32'd16, 32'h55, 4'hF);
        busRead(c_BASE + 32'd4, 1'b1, rd, hit);
        checkValue("outNoPush", rd, 32'h2 | c_PAR_FLAG);
        busRead(c_BASE + 32'd4, 1'b0, rd, hit);
        checkValue("noReadEnData", rd, 0);
        checkValue("noReadEnHit", hit, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
`default_nettype wire
